rs_latch_bank_sequencer: RTL and testbench

//  Shares one gated, active-high-enable SR latch between NREQ requesters.

---
 rtl/rs_latch_pkg.sv | 23 ++
 rtl/rs_latch_bank_sequencer_rr_arbiter.sv | 31 +++
 rtl/rs_latch_bank_sequencer.sv | 144 ++++++++++++++
 tb/tb_rs_latch_bank_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_latch_pkg.sv
// Shared types and constants for the SR latch bank sequencer.
package rs_latch_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      CHECK  = 3'd4
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   // Largest of three phase lengths, used to size the phase counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rs_latch_bank_sequencer_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   idx
);

   logic          found;
   logic [PW-1:0] j;

   // Scan requesters starting at ptr, wrapping modulo NREQ.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         j = PW'((32'(ptr) + i) % NREQ);
         if (!found && req[j]) begin
            found  = 1'b1;
            win[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/rs_latch_bank_sequencer.sv
// Arbitrates NREQ requesters onto one gated SR latch, sequences s/r/en and
// checks the q/qn feedback against the requested value.
module rs_latch_bank_sequencer
   import rs_latch_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] op,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] done,
   output logic            err,
   output logic            busy,
   output logic            s,
   output logic            r,
   output logic            en,
   input  logic            q,
   input  logic            qn
);

   localparam int unsigned PW   = $clog2(NREQ);
   localparam int unsigned MAXC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
   localparam int unsigned CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] SETUP_END  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_END = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYC - 1);
   localparam logic [PW-1:0] LAST_IDX   = PW'(NREQ - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   ptr;
   logic            op_r;
   logic [NREQ-1:0] win;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   ptr_nxt;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req (req),
      .ptr (ptr),
      .win (win),
      .idx (win_idx)
   );

   // Pointer moves just past the winner so it is served last next round.
   assign ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);

   // Sequencer FSM: state, phase counter and all registered pin/handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         ptr   <= '0;
         op_r  <= OP_CLR;
         gnt   <= '0;
         done  <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
         s     <= 1'b0;
         r     <= 1'b0;
         en    <= 1'b0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt   <= win;
                  op_r  <= op[win_idx];
                  ptr   <= ptr_nxt;
                  s     <= op[win_idx];
                  r     <= ~op[win_idx];
                  busy  <= 1'b1;
                  cnt   <= '0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == SETUP_END) begin
                  cnt   <= '0;
                  en    <= 1'b1;
                  state <= STROBE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STROBE: begin
               if (cnt == STROBE_END) begin
                  cnt   <= '0;
                  en    <= 1'b0;
                  state <= HOLD;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               if (cnt == HOLD_END) begin
                  cnt   <= '0;
                  s     <= 1'b0;
                  r     <= 1'b0;
                  done  <= gnt;
                  err   <= (q != op_r) || (qn != ~op_r);
                  state <= CHECK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            CHECK: begin
               cnt   <= '0;
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               gnt   <= '0;
               busy  <= 1'b0;
               s     <= 1'b0;
               r     <= 1'b0;
               en    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Latch-safety and handshake invariants.
   a_no_sr : assert property (@(posedge clk) disable iff (rst) !(s && r));
   a_en_xor: assert property (@(posedge clk) disable iff (rst) en |-> (s ^ r));
   a_edge  : assert property (@(posedge clk) disable iff (rst)
                              (en != $past(en)) |-> ((s == $past(s)) && (r == $past(r))));
   a_gnt   : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_done  : assert property (@(posedge clk) disable iff (rst)
                              $onehot0(done) && ((done & ~gnt) == '0));

endmodule

// File: tb/tb_rs_latch_bank_sequencer.sv
// Self-checking bench for rs_latch_bank_sequencer with a transaction-level model.
module tb_rs_latch_bank_sequencer;

   localparam int NREQ = 4;
   localparam int S    = 1;
   localparam int T    = 2;
   localparam int H    = 1;
   localparam int L    = S + T + H;   // cycle offset of the CHECK cycle after grant

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] op  = '0;
   logic [NREQ-1:0] gnt, done;
   logic            err, busy, s, r, en, q, qn;
   logic            stuck = 1'b0;
   logic            lq    = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   rs_latch_bank_sequencer #(
      .NREQ(NREQ), .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .gnt(gnt), .done(done),
      .err(err), .busy(busy), .s(s), .r(r), .en(en), .q(q), .qn(qn)
   );

   always #5 clk = ~clk;

   // Gated SR latch model; stuck forces q low regardless of pins.
   always @(en or s or r or stuck) begin
      if (stuck) lq = 1'b0;
      else if (en && s && !r) lq = 1'b1;
      else if (en && r && !s) lq = 1'b0;
   end
   assign q  = lq;
   assign qn = ~lq;

   // Reference model: owner, captured op and cycle offset since grant.
   logic m_active = 1'b0;
   int   m_k      = 0;
   int   m_owner  = 0;
   int   m_ptr    = 0;
   logic m_op     = 1'b0;
   logic m_err    = 1'b0;

   function automatic int pick(input logic [NREQ-1:0] rq, input int p);
      for (int i = 0; i < NREQ; i++)
         if (rq[(p + i) % NREQ]) return (p + i) % NREQ;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0; m_k <= 0; m_owner <= 0; m_ptr <= 0; m_op <= 1'b0; m_err <= 1'b0;
      end else if (m_active) begin
         if (m_k == L) m_active <= 1'b0;
         else m_k <= m_k + 1;
         if (m_k == L - 1) m_err <= stuck & m_op;
      end else if (req != '0) begin
         m_owner  <= pick(req, m_ptr);
         m_op     <= op[pick(req, m_ptr)];
         m_ptr    <= (pick(req, m_ptr) + 1) % NREQ;
         m_k      <= 0;
         m_err    <= 1'b0;
         m_active <= 1'b1;
      end
   end

   logic [NREQ-1:0] m_oh;
   logic [2*NREQ+4:0] exp_vec, dut_vec;
   assign m_oh    = m_active ? (NREQ'(1) << m_owner) : '0;
   assign exp_vec = {m_oh, (m_k == L) ? m_oh : {NREQ{1'b0}},
                     m_active && (m_k == L) && m_err, m_active,
                     m_active && (m_k < L) && m_op, m_active && (m_k < L) && !m_op,
                     m_active && (m_k >= S) && (m_k < S + T)};
   assign dut_vec = {gnt, done, err, busy, s, r, en};

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; req = '0; op = '0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: outputs %b expected all zero", dut_vec);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dut_vec !== '0) begin
         n_errors++;
         $display("FAIL reset_idle: outputs %b expected all zero", dut_vec);
      end
   endtask

   task automatic test_single();
      req = 4'b0001; op = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL single_model c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
         n_checks++;
         if (en !== ((c == 1) || (c == 2))) begin
            n_errors++;
            $display("FAIL single_en c%0d: en %b expected %b", c, en, (c == 1) || (c == 2));
         end
         if (c == 0) begin
            n_checks++;
            if ({gnt, s, r} !== {4'b0001, 1'b1, 1'b0}) begin
               n_errors++;
               $display("FAIL single_grant: gnt/s/r %b expected 0001_1_0", {gnt, s, r});
            end
         end
         if (c == 4) begin
            n_checks++;
            if ({done, err, q} !== {4'b0001, 1'b0, 1'b1}) begin
               n_errors++;
               $display("FAIL single_done: done/err/q %b expected 0001_0_1", {done, err, q});
            end
            req = '0;
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int ng = 0;
      int glen = 0;
      logic [NREQ-1:0] pg = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; req = 4'b1111; op = 4'b0101;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL rr_model c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
         if (gnt != '0 && pg == '0) begin
            n_checks++;
            if (ng < 5 && oh_idx(gnt) !== exp_order[ng]) begin
               n_errors++;
               $display("FAIL rr_order #%0d: winner %0d expected %0d", ng, oh_idx(gnt), exp_order[ng]);
            end
            ng++;
            glen = 0;
         end
         if (gnt != '0) glen++;
         if (gnt == '0 && pg != '0) begin
            n_checks++;
            if (glen !== 5) begin
               n_errors++;
               $display("FAIL rr_gnt_len: %0d cycles expected 5", glen);
            end
         end
         if (done != '0) begin
            n_checks++;
            if (q !== op[oh_idx(done)]) begin
               n_errors++;
               $display("FAIL rr_latch: q %b expected %b", q, op[oh_idx(done)]);
            end
         end
         pg = gnt;
      end
      req = '0;
      n_checks++;
      if (ng !== 5) begin
         n_errors++;
         $display("FAIL rr_count: %0d grants expected 5", ng);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_stuck();
      int pulses = 0;
      stuck = 1'b1; req = 4'b0001; op = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL stuck_model c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
         n_checks++;
         if (err !== (done != '0)) begin
            n_errors++;
            $display("FAIL stuck_err c%0d: err %b done %b expected err with done", c, err, done);
         end
         if (err) pulses++;
         if (done != '0) req = '0;
      end
      n_checks++;
      if (pulses !== 1) begin
         n_errors++;
         $display("FAIL stuck_pulses: %0d err pulses expected 1", pulses);
      end
      stuck = 1'b0;
   endtask

   task automatic test_reset_mid();
      req = 4'b0100; op = 4'b0100;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL rmid_model c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
      end
      n_checks++;
      if (en !== 1'b1) begin
         n_errors++;
         $display("FAIL rmid_strobe: en %b expected 1", en);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (dut_vec !== '0) begin
         n_errors++;
         $display("FAIL rmid_async: outputs %b expected all zero", dut_vec);
      end
      @(negedge clk);
      n_checks++;
      if (dut_vec !== '0) begin
         n_errors++;
         $display("FAIL rmid_in_reset: outputs %b expected all zero", dut_vec);
      end
      rst = 1'b0; req = 4'b1111; op = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0001) begin
         n_errors++;
         $display("FAIL rmid_first: gnt %b expected 0001", gnt);
      end
      req = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL rmid_after c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_drop_flip();
      // ptr is 1 here, so requester 2 wins and the pointer moves to 3.
      req = 4'b0100; op = 4'b0100;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL drop_model c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
         if (c < 4) begin
            n_checks++;
            if ({s, r} !== 2'b10) begin
               n_errors++;
               $display("FAIL drop_sr c%0d: s/r %b expected 10", c, {s, r});
            end
         end
         if (c == 4) begin
            n_checks++;
            if ({done, err} !== {4'b0100, 1'b0}) begin
               n_errors++;
               $display("FAIL drop_done: done/err %b expected 0100_0", {done, err});
            end
         end
         if (c == 6) begin
            n_checks++;
            if (gnt !== 4'b1000) begin
               n_errors++;
               $display("FAIL drop_next: gnt %b expected 1000", gnt);
            end
         end
         if (c == 0) req = 4'b1001;
         if (c == 3) op = 4'b0000;
      end
      req = '0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_random();
      logic pe, ps, pr;
      @(negedge clk);
      pe = en; ps = s; pr = r;
      for (int c = 0; c < 10000; c++) begin
         req = NREQ'($urandom_range(0, 15));
         op  = NREQ'($urandom_range(0, 15));
         @(negedge clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL rand_model c%0d: outputs %b expected %b", c, dut_vec, exp_vec);
         end
         n_checks++;
         if (s && r) begin
            n_errors++;
            $display("FAIL rand_sr c%0d: s=%b r=%b never both 1", c, s, r);
         end
         n_checks++;
         if (en && !(s ^ r)) begin
            n_errors++;
            $display("FAIL rand_en c%0d: en=%b s=%b r=%b expected s^r with en", c, en, s, r);
         end
         n_checks++;
         if ((en !== pe) && ((s !== ps) || (r !== pr))) begin
            n_errors++;
            $display("FAIL rand_edge c%0d: en %b->%b with s/r %b->%b", c, pe, en, {ps, pr}, {s, r});
         end
         pe = en; ps = s; pr = r;
      end
      req = '0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stuck();
      test_reset_mid();
      test_drop_flip();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
